// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch (IF) and load/store (MEM).
// Optional bus-timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_stallreq,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_W/8-1:0]   mem_sel,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_stallreq,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W/8-1:0]   bus_sel,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err,
  output logic [2:0]            dbg_state
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [31:0] TIMEOUT_L = TIMEOUT;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_BUSY = 3'd1,
    S_IF_BUSY  = 3'd2,
    S_MEM_HOLD = 3'd3,
    S_IF_HOLD  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [SEL_W-1:0]     bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]    bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]    mem_data_q, mem_data_d;
  logic [DATA_W-1:0]    if_data_q, if_data_d;

  logic busy;
  logic done;
  logic timeout_hit;
  logic err_gate_mem;
  logic err_gate_if;
  logic unused_cfg;

  // Bus handshake: bus_req rises the cycle after a request is accepted in IDLE and all
  // bus_* outputs stay frozen until the slave pulses bus_ack for one cycle; bus_req is
  // low the cycle after, so at least one IDLE cycle separates transactions.
  assign busy = (state_q == S_MEM_BUSY) || (state_q == S_IF_BUSY);
  assign done = busy && (bus_ack || timeout_hit);

  // Only the MEM and IF stall bits steer this block; the rest of the vector is ignored.
  assign unused_cfg = ^{stall[5], stall[3:2], stall[0], TIMEOUT_L[0]};

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_mem_q;

  assign timeout_hit = busy && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d       = (busy && !bus_ack && !timeout_hit) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_mem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= timeout_hit;
      err_mem_q <= (state_q == S_MEM_BUSY);
    end
  end

  assign bus_err      = err_q;
  assign err_gate_mem = err_q && err_mem_q;
  assign err_gate_if  = err_q && !err_mem_q;
`else
  assign timeout_hit  = 1'b0;
  assign bus_err      = 1'b0;
  assign err_gate_mem = 1'b0;
  assign err_gate_if  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_data_q  <= '0;
      if_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_data_q  <= mem_data_d;
      if_data_q   <= if_data_d;
    end
  end

  // A flushed transaction still runs to completion; flush only changes where it lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (mem_req)     state_d = S_MEM_BUSY;
          else if (if_req) state_d = S_IF_BUSY;
        end
      end
      S_MEM_BUSY: if (done) state_d = (stall[4] && !flush) ? S_MEM_HOLD : S_IDLE;
      S_IF_BUSY:  if (done) state_d = (stall[1] && !flush) ? S_IF_HOLD : S_IDLE;
      S_MEM_HOLD: if (!stall[4] || flush) state_d = S_IDLE;
      S_IF_HOLD:  if (!stall[1] || flush) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_data_d  = mem_data_q;
    if_data_d   = if_data_q;
    if (state_q == S_IDLE && !flush) begin
      if (mem_req) begin
        bus_req_d   = 1'b1;
        bus_we_d    = mem_we;
        bus_sel_d   = mem_sel;
        bus_addr_d  = mem_addr;
        bus_wdata_d = mem_wdata;
      end else if (if_req) begin
        bus_req_d   = 1'b1;
        bus_we_d    = 1'b0;
        bus_sel_d   = {SEL_W{1'b1}};
        bus_addr_d  = if_addr;
      end
    end
    if (done) bus_req_d = 1'b0;
    // An aborted transaction leaves zero in the owner's held register.
    if (state_q == S_MEM_BUSY && done && !flush) mem_data_d = bus_ack ? bus_rdata : '0;
    if (state_q == S_IF_BUSY && done && !flush)  if_data_d  = bus_ack ? bus_rdata : '0;
  end

  always_comb begin
    bus_req      = bus_req_q;
    bus_we       = bus_we_q;
    bus_sel      = bus_sel_q;
    bus_addr     = bus_addr_q;
    bus_wdata    = bus_wdata_q;
    dbg_state    = state_q;
    mem_rdata    = (state_q == S_MEM_BUSY && bus_ack) ? bus_rdata : mem_data_q;
    if_rdata     = (state_q == S_IF_BUSY && bus_ack) ? bus_rdata : if_data_q;
    mem_stallreq = mem_req && !flush && !(state_q == S_MEM_BUSY && bus_ack)
                   && (state_q != S_MEM_HOLD) && !err_gate_mem;
    if_stallreq  = if_req && !flush && !(state_q == S_IF_BUSY && bus_ack)
                   && (state_q != S_IF_HOLD) && !err_gate_if;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a scoreboarded random
// back-to-back sequence. Define BUS_TIMEOUT_EN for both DUT and bench to exercise the abort path.
module tb_mem_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_stallreq;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_stallreq;
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          bus_err;
  logic [2:0]    dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_if;
  logic [DW-1:0] last_mem;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 6'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
    vec_cnt++; if (bus_we !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_we got=%0h exp=0", bus_we); end
    vec_cnt++; if (bus_err !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_err got=%0h exp=0", bus_err); end
    vec_cnt++; if (bus_sel !== 4'h0) begin err_cnt++; $display("FAIL rst_bus_sel got=%0h exp=0", bus_sel); end
    vec_cnt++; if (bus_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_bus_addr got=%0h exp=0", bus_addr); end
    vec_cnt++; if (bus_wdata !== 32'h0) begin err_cnt++; $display("FAIL rst_bus_wdata got=%0h exp=0", bus_wdata); end
    vec_cnt++; if (if_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_if_rdata got=%0h exp=0", if_rdata); end
    vec_cnt++; if (mem_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_mem_rdata got=%0h exp=0", mem_rdata); end
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    last_if = '0;
    last_mem = '0;
  endtask

  task automatic test_if_fetch();
    logic [DW-1:0] exp;
    tick(); if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL if_req_cycle_bus_req got=%0h exp=0", bus_req); end
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL if_stall_c0 got=%0h exp=1", if_stallreq); end
    tick();
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL if_bus_req_rise got=%0h exp=1", bus_req); end
    vec_cnt++; if (bus_addr !== 32'h100) begin err_cnt++; $display("FAIL if_bus_addr got=%0h exp=100", bus_addr); end
    vec_cnt++; if (bus_we !== 1'b0) begin err_cnt++; $display("FAIL if_bus_we got=%0h exp=0", bus_we); end
    vec_cnt++; if (bus_sel !== 4'hf) begin err_cnt++; $display("FAIL if_bus_sel got=%0h exp=f", bus_sel); end
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL if_stall_c1 got=%0h exp=1", if_stallreq); end
    tick();
    @(negedge clk);
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL if_stall_c2 got=%0h exp=1", if_stallreq); end
    tick(); bus_ack = 1'b1; bus_rdata = 32'h3C011234; exp_q.push_back(32'h3C011234);
    @(negedge clk);
    exp = exp_q.pop_front();
    vec_cnt++; if (if_rdata !== exp) begin err_cnt++; $display("FAIL if_rdata_ack got=%0h exp=%0h", if_rdata, exp); end
    vec_cnt++; if (if_stallreq !== 1'b0) begin err_cnt++; $display("FAIL if_stall_ack got=%0h exp=0", if_stallreq); end
    last_if = exp;
    tick(); bus_ack = 1'b0; bus_rdata = '0; if_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL if_bus_req_drop got=%0h exp=0", bus_req); end
    vec_cnt++; if (if_rdata !== last_if) begin err_cnt++; $display("FAIL if_rdata_held got=%0h exp=%0h", if_rdata, last_if); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] exp;
    tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL pri_if_stall_c0 got=%0h exp=1", if_stallreq); end
    vec_cnt++; if (mem_stallreq !== 1'b1) begin err_cnt++; $display("FAIL pri_mem_stall_c0 got=%0h exp=1", mem_stallreq); end
    tick();
    @(negedge clk);
    vec_cnt++; if (bus_addr !== 32'h2000) begin err_cnt++; $display("FAIL pri_mem_first got=%0h exp=2000", bus_addr); end
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL pri_if_stall_c1 got=%0h exp=1", if_stallreq); end
    tick(); bus_ack = 1'b1; bus_rdata = 32'h11112222; exp_q.push_back(32'h11112222);
    @(negedge clk);
    exp = exp_q.pop_front();
    vec_cnt++; if (mem_rdata !== exp) begin err_cnt++; $display("FAIL pri_mem_rdata got=%0h exp=%0h", mem_rdata, exp); end
    vec_cnt++; if (mem_stallreq !== 1'b0) begin err_cnt++; $display("FAIL pri_mem_stall_ack got=%0h exp=0", mem_stallreq); end
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL pri_if_stall_ack got=%0h exp=1", if_stallreq); end
    last_mem = exp;
    tick(); bus_ack = 1'b0; bus_rdata = '0; mem_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL pri_idle_gap got=%0h exp=0", bus_req); end
    vec_cnt++; if (if_stallreq !== 1'b1) begin err_cnt++; $display("FAIL pri_if_stall_gap got=%0h exp=1", if_stallreq); end
    tick();
    @(negedge clk);
    vec_cnt++; if (bus_addr !== 32'h104) begin err_cnt++; $display("FAIL pri_if_second got=%0h exp=104", bus_addr); end
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL pri_if_bus_req got=%0h exp=1", bus_req); end
    tick(); bus_ack = 1'b1; bus_rdata = 32'h22223333; exp_q.push_back(32'h22223333);
    @(negedge clk);
    exp = exp_q.pop_front();
    vec_cnt++; if (if_rdata !== exp) begin err_cnt++; $display("FAIL pri_if_rdata got=%0h exp=%0h", if_rdata, exp); end
    last_if = exp;
    tick(); bus_ack = 1'b0; bus_rdata = '0; if_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (mem_rdata !== last_mem) begin err_cnt++; $display("FAIL pri_mem_held got=%0h exp=%0h", mem_rdata, last_mem); end
  endtask

  task automatic test_store();
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h3000; mem_wdata = 32'hDEADBEEF;
    tick();
    mem_wdata = 32'h0; mem_sel = 4'hf; mem_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec_cnt++; if (bus_we !== 1'b1) begin err_cnt++; $display("FAIL st_bus_we c%0d got=%0h exp=1", k, bus_we); end
      vec_cnt++; if (bus_sel !== 4'b0011) begin err_cnt++; $display("FAIL st_bus_sel c%0d got=%0h exp=3", k, bus_sel); end
      vec_cnt++; if (bus_wdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL st_bus_wdata c%0d got=%0h exp=deadbeef", k, bus_wdata); end
      vec_cnt++; if (bus_addr !== 32'h3000) begin err_cnt++; $display("FAIL st_bus_addr c%0d got=%0h exp=3000", k, bus_addr); end
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    vec_cnt++; if (mem_stallreq !== 1'b0) begin err_cnt++; $display("FAIL st_stall_ack got=%0h exp=0", mem_stallreq); end
    last_mem = 32'hA5A5A5A5;
    tick(); bus_ack = 1'b0; bus_rdata = '0; mem_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL st_bus_req_drop got=%0h exp=0", bus_req); end
    vec_cnt++; if (mem_rdata !== last_mem) begin err_cnt++; $display("FAIL st_held got=%0h exp=%0h", mem_rdata, last_mem); end
  endtask

  task automatic test_mem_hold();
    tick(); mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h4000;
    tick();
    tick(); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; stall = 6'b010000;
    @(negedge clk);
    vec_cnt++; if (mem_rdata !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL hold_pass got=%0h exp=cafef00d", mem_rdata); end
    last_mem = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      tick(); bus_ack = 1'b0; bus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      vec_cnt++; if (mem_rdata !== last_mem) begin err_cnt++; $display("FAIL hold_rdata c%0d got=%0h exp=%0h", k, mem_rdata, last_mem); end
      vec_cnt++; if (mem_stallreq !== 1'b0) begin err_cnt++; $display("FAIL hold_stallreq c%0d got=%0h exp=0", k, mem_stallreq); end
      vec_cnt++; if (dbg_state !== 3'd3) begin err_cnt++; $display("FAIL hold_state c%0d got=%0d exp=3", k, dbg_state); end
    end
    tick(); stall = 6'b0; mem_req = 1'b0; bus_rdata = '0;
    tick();
    @(negedge clk);
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL hold_exit got=%0d exp=0", dbg_state); end
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL hold_bus_req got=%0h exp=0", bus_req); end
  endtask

  task automatic test_flush();
    tick(); if_req = 1'b1; if_addr = 32'h200;
    tick(); flush = 1'b1;
    @(negedge clk);
    vec_cnt++; if (if_stallreq !== 1'b0) begin err_cnt++; $display("FAIL fl_stall got=%0h exp=0", if_stallreq); end
    tick();
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL fl_not_cut got=%0h exp=1", bus_req); end
    tick(); bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(negedge clk);
    vec_cnt++; if (if_stallreq !== 1'b0) begin err_cnt++; $display("FAIL fl_stall_ack got=%0h exp=0", if_stallreq); end
    tick(); bus_ack = 1'b0; bus_rdata = '0; flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL fl_state got=%0d exp=0", dbg_state); end
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL fl_bus_req got=%0h exp=0", bus_req); end
    vec_cnt++; if (if_rdata !== last_if) begin err_cnt++; $display("FAIL fl_discard got=%0h exp=%0h", if_rdata, last_if); end
  endtask

  task automatic test_reset_mid();
    tick(); mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h5000;
    tick();
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL rm_busy got=%0h exp=1", bus_req); end
    tick(); rst = 1'b1; mem_req = 1'b0;
    tick(); rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL rm_bus_req got=%0h exp=0", bus_req); end
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL rm_state got=%0d exp=0", dbg_state); end
    vec_cnt++; if (mem_rdata !== 32'h0) begin err_cnt++; $display("FAIL rm_mem_rdata got=%0h exp=0", mem_rdata); end
    last_mem = '0;
    last_if = '0;
  endtask

  task automatic test_timeout();
    tick(); mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h6000;
`ifdef BUS_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      tick();
      @(negedge clk);
      vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL to_busy c%0d got=%0h exp=1", k, bus_req); end
      vec_cnt++; if (bus_err !== 1'b0) begin err_cnt++; $display("FAIL to_err_early c%0d got=%0h exp=0", k, bus_err); end
    end
    tick();
    @(negedge clk);
    vec_cnt++; if (bus_err !== 1'b1) begin err_cnt++; $display("FAIL to_err_pulse got=%0h exp=1", bus_err); end
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL to_bus_req_drop got=%0h exp=0", bus_req); end
    vec_cnt++; if (mem_stallreq !== 1'b0) begin err_cnt++; $display("FAIL to_stallreq got=%0h exp=0", mem_stallreq); end
    vec_cnt++; if (mem_rdata !== 32'h0) begin err_cnt++; $display("FAIL to_data_zero got=%0h exp=0", mem_rdata); end
    tick(); mem_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_err !== 1'b0) begin err_cnt++; $display("FAIL to_err_one_cycle got=%0h exp=0", bus_err); end
    tick(); bus_ack = 1'b1; bus_rdata = '0;
    tick(); bus_ack = 1'b0;
    last_mem = '0;
`else
    for (int k = 1; k <= TMO + 4; k++) begin
      tick();
      @(negedge clk);
      vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL nto_busy c%0d got=%0h exp=1", k, bus_req); end
      vec_cnt++; if (bus_err !== 1'b0) begin err_cnt++; $display("FAIL nto_err c%0d got=%0h exp=0", k, bus_err); end
      vec_cnt++; if (mem_stallreq !== 1'b1) begin err_cnt++; $display("FAIL nto_stall c%0d got=%0h exp=1", k, mem_stallreq); end
    end
    tick(); bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    vec_cnt++; if (mem_rdata !== 32'h0BADF00D) begin err_cnt++; $display("FAIL nto_rdata got=%0h exp=0badf00d", mem_rdata); end
    last_mem = 32'h0BADF00D;
    tick(); bus_ack = 1'b0; bus_rdata = '0; mem_req = 1'b0;
`endif
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL to_cleanup got=%0h exp=0", bus_req); end
  endtask

  task automatic do_txn(input bit is_mem, input logic [AW-1:0] addr, input int wait_n,
                        input logic [DW-1:0] data);
    int n;
    logic [DW-1:0] exp;
    logic [DW-1:0] obs;
    logic [DW-1:0] other;
    logic [DW-1:0] other_exp;
    tick();
    if (is_mem) begin
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = addr;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clk);
    n = 0;
    while (bus_req !== 1'b1 && n < 8) begin
      tick();
      n++;
      @(negedge clk);
    end
    vec_cnt++; if (n !== 1) begin err_cnt++; $display("FAIL b2b_latency got=%0d exp=1", n); end
    vec_cnt++; if (bus_addr !== addr) begin err_cnt++; $display("FAIL b2b_addr got=%0h exp=%0h", bus_addr, addr); end
    repeat (wait_n) tick();
    tick(); bus_ack = 1'b1; bus_rdata = data; exp_q.push_back(data);
    @(negedge clk);
    exp = exp_q.pop_front();
    obs = is_mem ? mem_rdata : if_rdata;
    vec_cnt++; if (obs !== exp) begin err_cnt++; $display("FAIL b2b_rdata mem=%0d got=%0h exp=%0h", is_mem, obs, exp); end
    if (is_mem) last_mem = exp; else last_if = exp;
    tick(); bus_ack = 1'b0; bus_rdata = '0; mem_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL b2b_gap got=%0h exp=0", bus_req); end
    other = is_mem ? if_rdata : mem_rdata;
    other_exp = is_mem ? last_if : last_mem;
    vec_cnt++; if (other !== other_exp) begin err_cnt++; $display("FAIL b2b_other_held got=%0h exp=%0h", other, other_exp); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      do_txn(1'($urandom_range(0, 1)), {$urandom_range(0, 32'hFFFF), 2'b00},
             int'($urandom_range(0, 3)), $urandom);
    end
    vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  // main sequence and report
  initial begin
    test_reset();
    test_if_fetch();
    test_priority();
    test_store();
    test_mem_hold();
    test_flush();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
